seq_chunk_adder: RTL

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

---
 rtl/seq_chunk_adder.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle add/subtract, CHUNK bits per clock
// Operands are latched on accept; chunk k is summed on the k-th CALC edge, LSB chunk first.
`timescale 1ns/1ps
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_c_out;
  logic             r_ovf;
  logic [KW-1:0]    r_k;

  int               w_shamt;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_chunk_res;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_top_carry_in;
  logic             w_last_chunk;
  logic             w_accept;

  // Chunk selection by shifting keeps every select constant-width.
  always_comb begin
    w_shamt        = int'(r_k) * CHUNK;
    w_a_chunk      = CHUNK'(r_a >> w_shamt);
    w_b_chunk      = CHUNK'(r_b >> w_shamt);
    w_chunk_res    = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_sum_next     = (r_sum & ~(CHUNK_MASK << w_shamt))
                   | (WIDTH'(w_chunk_res[CHUNK-1:0]) << w_shamt);
    // Carry into the chunk MSB, recovered from the MSB's own sum bit.
    w_top_carry_in = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_res[CHUNK-1];
    w_last_chunk   = (r_k == KW'(N - 1));
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last_chunk) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= sub | c_in;
        r_sum   <= '0;
        r_k     <= '0;
      end else if (r_state == S_CALC) begin
        r_sum   <= w_sum_next;
        r_carry <= w_chunk_res[CHUNK];
        r_c_out <= w_chunk_res[CHUNK];
        r_ovf   <= w_top_carry_in ^ w_chunk_res[CHUNK];
        r_k     <= w_last_chunk ? '0 : r_k + KW'(1);
      end
    end
  end

  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;

endmodule
